// File: rtl/regfile_scoreboard_pkg.sv
// Shared core constants for the register file: data width, register count
// and the derived register-address width.
package regfile_scoreboard_pkg;

    localparam int CORE_XLEN     = 32;
    localparam int CORE_NREG     = 32;
    localparam int CORE_AW       = $clog2(CORE_NREG);
    localparam int CORE_NRDPORTS = 2;

endpackage : regfile_scoreboard_pkg

// File: rtl/regfile_scoreboard_bits.sv
// Scoreboard: one pending bit per architectural register. A writeback clears
// the destination's bit and an issue sets it. When both target the same
// register in the same cycle, the issue wins because a newer producer is now
// in flight. Register 0 is never pending.
module regfile_scoreboard_bits
    import regfile_scoreboard_pkg::*;
#(
    parameter int NREG = CORE_NREG,
    localparam int AW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_en,
    input  logic [AW-1:0]   issue_addr,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    output logic [NREG-1:0] pending
);

    logic [NREG-1:0] pending_d;
    logic [NREG-1:0] pending_q;

    // Next-state pending vector: the clear is applied first, then the set, so the issue has priority.
    always_comb begin
        // NOTE: every always_comb output gets a full default first, so no path leaves it unassigned and no latch is inferred.
        pending_d = pending_q;
        if (wr_en && (wr_addr != '0)) begin
            pending_d[wr_addr] = 1'b0;
        end
        if (issue_en && (issue_addr != '0)) begin
            pending_d[issue_addr] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // Pending register, cleared by asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
        if (!rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;

endmodule : regfile_scoreboard_bits

// File: rtl/regfile_scoreboard.sv
// Register file with two registered read ports, one write port and a pending
// scoreboard. Reads see a same-cycle writeback through a bypass. Otherwise the
// valid flag reflects the scoreboard as it was before this cycle's update.
// Register 0 always reads as zero and is valid.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int XLEN = CORE_XLEN,
    parameter int NREG = CORE_NREG,
    localparam int AW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rd1,
    output logic            rd1_valid,
    output logic [XLEN-1:0] rd2,
    output logic            rd2_valid,
    input  logic            issue_en,
    input  logic [AW-1:0]   issue_addr,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    output logic [NREG-1:0] pending
);

    localparam int NP = CORE_NRDPORTS;

    logic [XLEN-1:0]         regs_d [NREG];
    logic [XLEN-1:0]         regs_q [NREG];
    logic [NP-1:0][AW-1:0]   rs_addr;
    logic [NP-1:0][XLEN-1:0] rd_d;
    logic [NP-1:0][XLEN-1:0] rd_q;
    logic [NP-1:0]           rd_valid_d;
    logic [NP-1:0]           rd_valid_q;

    regfile_scoreboard_bits #(
        .NREG (NREG)
    ) u_bits (
        .clk        (clk),
        .rst        (rst),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .pending    (pending)
    );

    assign rs_addr = {rs2_addr, rs1_addr};

    // Next-state storage: a single write per cycle, and register 0 is never written.
    always_comb begin
        regs_d = regs_q;
        if (wr_en && (wr_addr != '0)) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    // Storage array, cleared to zero by asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: the array is reset on purpose because architectural state must read zero after reset; a plain RAM macro would not allow this.
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read-port next state: x0 gives zero, a same-cycle write is bypassed, otherwise the stored data is read with the old scoreboard.
    always_comb begin
        for (int p = 0; p < NP; p++) begin
            rd_d[p]       = regs_q[rs_addr[p]];
            rd_valid_d[p] = ~pending[rs_addr[p]];
            if (rs_addr[p] == '0) begin
                rd_d[p]       = '0;
                rd_valid_d[p] = 1'b1;
            end else if (wr_en && (wr_addr == rs_addr[p])) begin
                rd_d[p]       = wr_data;
                rd_valid_d[p] = !(issue_en && (issue_addr == rs_addr[p]));
            end
        end
    end

    // Registered read outputs. Reset leaves zero data flagged as valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q       <= '0;
            rd_valid_q <= '1;
        end else begin
            rd_q       <= rd_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd1       = rd_q[0];
    assign rd1_valid = rd_valid_q[0];
    assign rd2       = rd_q[1];
    assign rd2_valid = rd_valid_q[1];

endmodule : regfile_scoreboard

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard. Each scenario task drives its inputs,
// advances one clock and compares the outputs against hand-computed values.
module tb_regfile_scoreboard;

    logic        clk;
    logic        rst;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rd1;
    logic        rd1_valid;
    logic [31:0] rd2;
    logic        rd2_valid;
    logic        issue_en;
    logic [4:0]  issue_addr;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] pending;

    int total = 0;
    int bad   = 0;

    regfile_scoreboard dut (
        .clk        (clk),
        .rst        (rst),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rd1        (rd1),
        .rd1_valid  (rd1_valid),
        .rd2        (rd2),
        .rd2_valid  (rd2_valid),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .pending    (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge, where the registered outputs are stable.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_en = 1'b0;
        wr_en    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        total++; if (rd1 !== 32'h0) begin bad++; $display("FAIL reset_rd1: got %h want %h", rd1, 32'h0); end
        total++; if (rd1_valid !== 1'b1) begin bad++; $display("FAIL reset_rd1_valid: got %b want 1", rd1_valid); end
        total++; if (rd2_valid !== 1'b1) begin bad++; $display("FAIL reset_rd2_valid: got %b want 1", rd2_valid); end
        total++; if (pending !== 32'h0) begin bad++; $display("FAIL reset_pending: got %h want %h", pending, 32'h0); end
        rst = 1'b1;
    endtask

    task automatic test_basic();
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hDEADBEEF;
        rs1_addr = 5'd0; rs2_addr = 5'd0;
        tick();
        idle();
        rs1_addr = 5'd3; rs2_addr = 5'd3;
        tick();
        total++; if (rd1 !== 32'hDEADBEEF) begin bad++; $display("FAIL basic_rd1: got %h want %h", rd1, 32'hDEADBEEF); end
        total++; if (rd1_valid !== 1'b1) begin bad++; $display("FAIL basic_rd1_valid: got %b want 1", rd1_valid); end
        total++; if (rd2 !== 32'hDEADBEEF) begin bad++; $display("FAIL basic_rd2_same_reg: got %h want %h", rd2, 32'hDEADBEEF); end
        total++; if (rd2_valid !== 1'b1) begin bad++; $display("FAIL basic_rd2_valid: got %b want 1", rd2_valid); end
    endtask

    task automatic test_scoreboard();
        // An issue and a read of the same register in one cycle: the valid flag comes from the old scoreboard.
        issue_en = 1'b1; issue_addr = 5'd7; rs1_addr = 5'd7;
        tick();
        total++; if (rd1_valid !== 1'b1) begin bad++; $display("FAIL sb_pre_update_valid: got %b want 1", rd1_valid); end
        idle();
        tick();
        total++; if (rd1_valid !== 1'b0) begin bad++; $display("FAIL sb_pending_valid: got %b want 0", rd1_valid); end
        total++; if (rd1 !== 32'h0) begin bad++; $display("FAIL sb_pending_data: got %h want %h", rd1, 32'h0); end
        total++; if (pending !== 32'h0000_0080) begin bad++; $display("FAIL sb_pending_bit: got %h want %h", pending, 32'h80); end
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12345678;
        tick();
        total++; if (rd1 !== 32'h12345678) begin bad++; $display("FAIL sb_bypass_rd1: got %h want %h", rd1, 32'h12345678); end
        total++; if (rd1_valid !== 1'b1) begin bad++; $display("FAIL sb_bypass_valid: got %b want 1", rd1_valid); end
        total++; if (pending !== 32'h0) begin bad++; $display("FAIL sb_cleared: got %h want %h", pending, 32'h0); end
        idle();
        tick();
        total++; if (rd1 !== 32'h12345678) begin bad++; $display("FAIL sb_stored_rd1: got %h want %h", rd1, 32'h12345678); end
    endtask

    task automatic test_x0();
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
        issue_en = 1'b1; issue_addr = 5'd0;
        rs1_addr = 5'd0; rs2_addr = 5'd0;
        tick();
        total++; if (rd1 !== 32'h0) begin bad++; $display("FAIL x0_bypass_rd1: got %h want %h", rd1, 32'h0); end
        idle();
        tick();
        total++; if (rd1 !== 32'h0) begin bad++; $display("FAIL x0_rd1: got %h want %h", rd1, 32'h0); end
        total++; if (rd1_valid !== 1'b1) begin bad++; $display("FAIL x0_rd1_valid: got %b want 1", rd1_valid); end
        total++; if (rd2 !== 32'h0) begin bad++; $display("FAIL x0_rd2: got %h want %h", rd2, 32'h0); end
        total++; if (rd2_valid !== 1'b1) begin bad++; $display("FAIL x0_rd2_valid: got %b want 1", rd2_valid); end
        total++; if (pending !== 32'h0) begin bad++; $display("FAIL x0_pending: got %h want %h", pending, 32'h0); end
    endtask

    task automatic test_collision();
        issue_en = 1'b1; issue_addr = 5'd9;
        tick();
        idle();
        tick();
        total++; if (pending !== 32'h0000_0200) begin bad++; $display("FAIL col_setup_pending: got %h want %h", pending, 32'h200); end
        issue_en = 1'b1; issue_addr = 5'd9;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5A5A5A5;
        rs2_addr = 5'd9;
        tick();
        total++; if (pending !== 32'h0000_0200) begin bad++; $display("FAIL col_pending_kept: got %h want %h", pending, 32'h200); end
        total++; if (rd2_valid !== 1'b0) begin bad++; $display("FAIL col_bypass_valid: got %b want 0", rd2_valid); end
        idle();
        tick();
        total++; if (rd2 !== 32'hA5A5A5A5) begin bad++; $display("FAIL col_rd2: got %h want %h", rd2, 32'hA5A5A5A5); end
        total++; if (rd2_valid !== 1'b0) begin bad++; $display("FAIL col_rd2_valid: got %b want 0", rd2_valid); end
    endtask

    task automatic test_legal_write();
        // r9 is still pending. A write to the non-pending r12 must leave the scoreboard unchanged.
        wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h0BADF00D;
        rs1_addr = 5'd12; rs2_addr = 5'd9;
        tick();
        total++; if (rd1 !== 32'h0BADF00D) begin bad++; $display("FAIL lw_bypass_rd1: got %h want %h", rd1, 32'h0BADF00D); end
        total++; if (rd1_valid !== 1'b1) begin bad++; $display("FAIL lw_rd1_valid: got %b want 1", rd1_valid); end
        total++; if (rd2_valid !== 1'b0) begin bad++; $display("FAIL lw_r9_valid: got %b want 0", rd2_valid); end
        total++; if (pending !== 32'h0000_0200) begin bad++; $display("FAIL lw_pending: got %h want %h", pending, 32'h200); end
        idle();
        tick();
        total++; if (rd1 !== 32'h0BADF00D) begin bad++; $display("FAIL lw_stored_rd1: got %h want %h", rd1, 32'h0BADF00D); end
    endtask

    task automatic test_reset_mid();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h00000055;
        rs1_addr = 5'd5; rs2_addr = 5'd9;
        tick();
        // Inputs for an issue and a write are in flight when reset asserts partway through the cycle.
        issue_en = 1'b1; issue_addr = 5'd11;
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h00000077;
        #2;
        rst = 1'b0;
        #1;
        total++; if (rd1 !== 32'h0) begin bad++; $display("FAIL rstm_async_rd1: got %h want %h", rd1, 32'h0); end
        total++; if (rd1_valid !== 1'b1) begin bad++; $display("FAIL rstm_async_rd1_valid: got %b want 1", rd1_valid); end
        total++; if (pending !== 32'h0) begin bad++; $display("FAIL rstm_async_pending: got %h want %h", pending, 32'h0); end
        tick();
        total++; if (pending !== 32'h0) begin bad++; $display("FAIL rstm_held_pending: got %h want %h", pending, 32'h0); end
        idle();
        rst = 1'b1;
        tick();
        total++; if (rd1 !== 32'h0) begin bad++; $display("FAIL rstm_r5_rd1: got %h want %h", rd1, 32'h0); end
        total++; if (rd1_valid !== 1'b1) begin bad++; $display("FAIL rstm_r5_valid: got %b want 1", rd1_valid); end
        total++; if (rd2 !== 32'h0) begin bad++; $display("FAIL rstm_r9_rd2: got %h want %h", rd2, 32'h0); end
        total++; if (rd2_valid !== 1'b1) begin bad++; $display("FAIL rstm_r9_valid: got %b want 1", rd2_valid); end
        total++; if (pending !== 32'h0) begin bad++; $display("FAIL rstm_pending: got %h want %h", pending, 32'h0); end
        // Normal operation resumes straight away.
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h00000044;
        issue_en = 1'b1; issue_addr = 5'd6;
        rs1_addr = 5'd4; rs2_addr = 5'd6;
        tick();
        total++; if (rd1 !== 32'h00000044) begin bad++; $display("FAIL post_rd1: got %h want %h", rd1, 32'h44); end
        total++; if (rd2_valid !== 1'b1) begin bad++; $display("FAIL post_rd2_valid: got %b want 1", rd2_valid); end
        total++; if (pending !== 32'h0000_0040) begin bad++; $display("FAIL post_pending: got %h want %h", pending, 32'h40); end
        idle();
    endtask

    initial begin
        rst        = 1'b0;
        rs1_addr   = '0;
        rs2_addr   = '0;
        issue_en   = 1'b0;
        issue_addr = '0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        test_reset();
        test_basic();
        test_scoreboard();
        test_x0();
        test_collision();
        test_legal_write();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_regfile_scoreboard

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter XLEN, default 32: data width of every register and data port.
REQ-002 SHALL have parameter NREG, default 32: number of architectural registers; address width is log2(NREG).
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on posedge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port rs1_addr, input, 5: read port 1 address.
REQ-006 SHALL have port rs2_addr, input, 5: read port 2 address.
REQ-007 SHALL have port rd1, output, XLEN: registered read data for port 1.
REQ-008 SHALL have port rd1_valid, output, 1: rd1 holds committed, non-pending data.
REQ-009 SHALL have port rd2, output, XLEN: registered read data for port 2.
REQ-010 SHALL have port rd2_valid, output, 1: rd2 holds committed, non-pending data.
REQ-011 SHALL have port issue_en, input, 1: marks issue_addr pending, meaning a result is in flight.
REQ-012 SHALL have port issue_addr, input, 5: destination of the in-flight result.
REQ-013 SHALL have port wr_en, input, 1: writeback strobe, driven by the upstream valid-tagged result register.
REQ-014 SHALL have port wr_addr, input, 5: writeback destination.
REQ-015 SHALL have port wr_data, input, XLEN: writeback data.
REQ-016 SHALL have port pending, output, NREG: current scoreboard bit per register.

Function
REQ-017 SHALL provide read latency of exactly 1 cycle: rd1, rd1_valid, rd2 and rd2_valid update at the posedge following address presentation.
REQ-018 SHALL always return 0 with valid=1 for address 0.
REQ-019 SHALL ignore writes and issues targeting address 0; pending[0] SHALL stay 0.
REQ-020 SHALL write wr_data into reg[wr_addr] at posedge when wr_en=1 and clear pending[wr_addr].
REQ-021 SHALL set pending[issue_addr] at posedge when issue_en=1.
REQ-022 SHALL handle issue and writeback to the same non-zero address in the same cycle as follows: data is written and the pending bit SHALL end set, because the new producer wins.
REQ-023 SHALL bypass a same-cycle write: when wr_en=1 and wr_addr=rsN_addr!=0, rdN SHALL capture wr_data with rdN_valid=1, unless the same-cycle issue re-marks that address.
REQ-024 SHALL otherwise set rdN_valid = NOT pending[rsN_addr], sampled before this cycle's update; rdN SHALL carry the stored value even when invalid.
REQ-025 SHALL treat a write to a non-pending register as legal, with data updated and pending left 0.
REQ-026 SHALL let both read ports address the same register concurrently with identical results.
REQ-027 SHALL update all state only on clk; there are no combinational paths from inputs to outputs.

Reset
REQ-028 SHALL, on rst=0 and independent of clk: set all registers to 0, clear all pending bits, set rd1 and rd2 to 0, and set rd1_valid and rd2_valid to 1.
REQ-029 SHALL, on reset assertion mid-operation, discard any in-flight issue or write; the first posedge after rst returns to 1 operates normally.

Structure
REQ-030 SHALL take XLEN, NREG and the address width from the shared core package, alongside the other register-width constants.
REQ-031 SHALL place the scoreboard, meaning the pending vector plus the issue/clear priority logic, in sub-module regfile_scoreboard_bits; the storage array and read ports stay in the top module.

Verification
REQ-032 SHALL verify reset: assert rst=0 mid-run, read r5 -> rd1=0, rd1_valid=1, pending=0.
REQ-033 SHALL verify basic write/read: write r3=0xDEADBEEF, read r3 next cycle -> rd1=0xDEADBEEF, rd1_valid=1.
REQ-034 SHALL verify scoreboard: issue r7, read r7 -> rd1_valid=0; then write r7=0x12345678 while reading r7 in the same cycle -> rd1=0x12345678, rd1_valid=1, pending[7]=0.
REQ-035 SHALL verify x0: write r0=0xFFFFFFFF with issue r0, then read r0 on both ports -> 0 with valid=1, pending[0]=0.
REQ-036 SHALL verify the collision: with r9 pending, issue r9 and write r9=0xA5A5A5A5 in the same cycle -> pending[9]=1; the next read gives rd2=0xA5A5A5A5 with rd2_valid=0.
